lamp_gate_cluster: RTL and testbench
====================================

# lamp_gate_cluster

- Parametrised successor to the fixed two-lamp AND gate in the wiring fabric: one logic gate with `LAMP_COUNT` attached lamps, a selectable gate mode, and an optional faulty-lamp (random) mode.
- Sits between wire pulse sources (lamps on incoming wires) and output/next-stage wires. It owns lamp toggle state, gate-state change detection and once-per-pass firing suppression.
- It emits a one-cycle `out` pulse whenever the gate fires.

## Interface

Parameters:

- `LAMP_COUNT`, default 2: number of lamps. Legal range 1..8.
- `MODE`, default 0: gate mode, one of AND=0, OR=1, NAND=2, NOR=3, XOR=4, XNOR=5. Any other value fails elaboration.
- `FAULTY`, default 0: when 1, the gate is a faulty-lamp gate and `MODE` is ignored.
- `LAMP_INIT`, default 0: `LAMP_COUNT`-bit initial lamp vector.
- `LFSR_SEED`, default 16'hACE1: nonzero LFSR seed.

Ports:

- `clk`, input, 1: the single clock. Everything is rising-edge.
- `reset`, input, 1: asynchronous, active-low reset.
- `logic_reset`, input, 1: synchronous, active-high. Clears the fired flag; starts a new wire pass.
- `in`, input, `LAMP_COUNT`: one-cycle wire pulses. Bit i toggles lamp i.
- `out`, output, 1: registered one-cycle fire pulse.
- `suppressed`, output, 1: registered one-cycle pulse, raised when a fire was blocked by the fired flag.
- `lamps`, output, `LAMP_COUNT`: current lamp state.
- `gate_state`, output, 1: current registered gate result. Always 0 when `FAULTY`=1.
- `busy`, output, 1: high when `|in` or `out` is high. Feeds `wiring_running`.

## Operation

- Lamps: `lamps_next = lamps ^ in`. All bits asserted in the same cycle toggle together.
- Normal mode (`FAULTY`=0):
  - `eval_next` = reduction of `lamps_next` per `MODE`.
  - Change = `eval_next != gate_state`.
  - A change fires when the fired flag is clear. A change with the fired flag set raises `suppressed` instead.
  - `gate_state` updates on every change, whether or not it fired.
- Faulty mode (`FAULTY`=1), a draw occurs in any cycle with `|in`:
  - `r = (lfsr * LAMP_COUNT) >> 16`, giving range 0..`LAMP_COUNT`-1.
  - Candidate fire when `r < popcount(lamps_next)`.
  - The LFSR advances only on draw cycles.
  - The fired flag applies exactly as in normal mode.
- Fired flag:
  - `fired_next = (fired & ~logic_reset) | fire`.
  - When `logic_reset` and a fire candidate arrive in the same cycle, the fire proceeds and the flag ends set.
- Net-zero toggles:
  - Normal mode: when several toggles leave the reduction unchanged (e.g. XOR, two bits), there is no change, so no `out` and no `suppressed`.
  - Faulty mode: a draw still occurs.
- LFSR: 16-bit Galois, taps mask 16'hB400, shift right. It never reaches zero.

## Timing

- Latency: `in` pulse in cycle t gives `lamps`, `gate_state`, `out` and `suppressed` updated in cycle t+1.
- `out` and `suppressed` are never high in the same cycle. Each is high for exactly one cycle per event.
- Back-to-back `in` pulses every cycle are legal; each cycle is evaluated independently.
- On `reset` assertion, asynchronously:
  - `lamps` = `LAMP_INIT`.
  - `gate_state` = reduction of `LAMP_INIT` (0 in faulty mode).
  - `fired` = 0, `out` = 0, `suppressed` = 0.
  - `lfsr` = `LFSR_SEED`.
  - `busy` follows `in`.
- Reset asserted mid-pass discards any pending pulse.
- First rising edge after deassertion behaves as a normal cycle.
- `logic_reset` does not alter `lamps`, `gate_state` or `lfsr`.

## Structure

- Shared `wiring_pkg` holds:
  - the `gate_mode_e` enum (AND..XNOR);
  - `LFSR_TAPS` = 16'hB400;
  - the max `LAMP_COUNT` constant (8);
  - a `gate_reduce(mode, vec)` function.
- One sub-module, `wiring_lfsr16`: ports `clk`, `reset`, `advance`, `value`; seed parameter.
- Popcount and the scaled-draw multiply stay inline in `lamp_gate_cluster`.

## Test plan

- AND, `LAMP_COUNT`=2, `LAMP_INIT`=0:
  - `in`=01 gives `lamps`=01, `gate_state`=0, no `out`.
  - Then `in`=10 gives `lamps`=11, `gate_state`=1, `out` pulse one cycle later.
- Same AND setup, no `logic_reset`: `in`=01 gives `gate_state`=0 and `suppressed` pulse, `out`=0. Then `logic_reset` followed by `in`=01 gives `gate_state`=1 and `out` pulse.
- XOR, `LAMP_COUNT`=2: `in`=11 in one cycle gives `lamps`=11, `gate_state` unchanged at 0, neither `out` nor `suppressed`.
- Faulty, `LAMP_COUNT`=1, `LAMP_INIT`=0:
  - `in`=1 gives popcount 1, `out` pulse always.
  - After `logic_reset`, `in`=1 gives popcount 0, no `out`.
  - The LFSR advances exactly twice; checked against the reference model from 16'hACE1.
- Faulty, `LAMP_COUNT`=4, 1000 random draws with `logic_reset` every cycle: fire rate tracks popcount/4 within ±5%, and matches the cycle-exact model.
- Assert `reset` low mid-pulse (`in`=11, AND): `out` stays 0 and `lamps`=`LAMP_INIT` immediately. After deassertion, operation resumes normally.

Source files
------------

// File: rtl/wiring_pkg.sv
// Shared wiring-fabric types and helpers: gate modes, LFSR taps and the
// masked gate reduction used by lamp gates.
package wiring_pkg;

  typedef enum logic [2:0] {
    GATE_AND  = 3'd0,
    GATE_OR   = 3'd1,
    GATE_NAND = 3'd2,
    GATE_NOR  = 3'd3,
    GATE_XOR  = 3'd4,
    GATE_XNOR = 3'd5
  } gate_mode_e;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam int          MAX_LAMPS = 8;

  // Only bits set in `used` take part; unused bits are neutral for every mode.
  function automatic logic gate_reduce(input gate_mode_e mode,
                                       input logic [MAX_LAMPS-1:0] vec,
                                       input logic [MAX_LAMPS-1:0] used);
    logic all_set;
    logic any_set;
    logic parity;
    all_set = &(vec | ~used);
    any_set = |(vec & used);
    parity  = ^(vec & used);
    case (mode)
      GATE_AND:  return all_set;
      GATE_OR:   return any_set;
      GATE_NAND: return ~all_set;
      GATE_NOR:  return ~any_set;
      GATE_XOR:  return parity;
      GATE_XNOR: return ~parity;
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/wiring_lfsr16.sv
// 16-bit right-shifting Galois LFSR that steps only when `advance` is high.
module wiring_lfsr16
  import wiring_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        advance,
  output logic [15:0] value
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  if (SEED == 16'h0) begin : g_bad_seed
    $error("wiring_lfsr16: SEED must be nonzero");
  end

  always_comb begin
    lfsr_d = lfsr_q;
    if (advance) begin
      lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign value = lfsr_q;

endmodule

// File: rtl/lamp_gate_cluster.sv
// One logic gate fed by LAMP_COUNT toggling lamps, with once-per-pass firing
// suppression and an optional faulty-lamp (random draw) mode.
module lamp_gate_cluster
  import wiring_pkg::*;
#(
  parameter int                    LAMP_COUNT = 2,
  parameter int                    MODE       = 0,
  parameter int                    FAULTY     = 0,
  parameter logic [LAMP_COUNT-1:0] LAMP_INIT  = '0,
  parameter logic [15:0]           LFSR_SEED  = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  logic_reset,
  input  logic [LAMP_COUNT-1:0] in,
  output logic                  out,
  output logic                  suppressed,
  output logic [LAMP_COUNT-1:0] lamps,
  output logic                  gate_state,
  output logic                  busy
);

  if (LAMP_COUNT < 1 || LAMP_COUNT > MAX_LAMPS) begin : g_bad_count
    $error("lamp_gate_cluster: LAMP_COUNT must be 1..8");
  end
  if (MODE < 0 || MODE > 5) begin : g_bad_mode
    $error("lamp_gate_cluster: MODE must be 0..5");
  end

  localparam gate_mode_e            GATE_MODE = gate_mode_e'(MODE[2:0]);
  localparam logic [MAX_LAMPS-1:0]  USED_MASK = MAX_LAMPS'((1 << LAMP_COUNT) - 1);
  localparam logic                  GATE_INIT = (FAULTY != 0) ? 1'b0 :
      gate_reduce(GATE_MODE, MAX_LAMPS'(LAMP_INIT), USED_MASK);

  logic [LAMP_COUNT-1:0] lamps_q, lamps_d;
  logic                  gate_q, gate_d;
  logic                  fired_q, fired_d;
  logic                  out_q, out_d;
  logic                  supp_q, supp_d;

  logic [15:0] lfsr_val;
  logic        lfsr_adv;
  logic        draw;
  logic [3:0]  pop;
  logic [3:0]  draw_r;
  logic        eval;
  logic        candidate;
  logic        fired_eff;

  wiring_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .advance (lfsr_adv),
    .value   (lfsr_val)
  );

  always_comb begin
    lamps_d = lamps_q ^ in;
    draw    = |in;
    pop     = '0;
    for (int i = 0; i < LAMP_COUNT; i++) begin
      pop = pop + 4'(lamps_d[i]);
    end
    // Scaled draw: top bits of lfsr*N land uniformly-ish in 0..N-1.
    draw_r    = 4'((32'(lfsr_val) * LAMP_COUNT) >> 16);
    eval      = gate_reduce(GATE_MODE, MAX_LAMPS'(lamps_d), USED_MASK);
    // A logic_reset in the same cycle already frees the gate to fire.
    fired_eff = fired_q & ~logic_reset;
    if (FAULTY != 0) begin
      candidate = draw && (draw_r < pop);
      gate_d    = 1'b0;
      lfsr_adv  = draw;
    end else begin
      candidate = (eval != gate_q);
      gate_d    = eval;
      lfsr_adv  = 1'b0;
    end
    out_d   = candidate & ~fired_eff;
    supp_d  = candidate & fired_eff;
    fired_d = fired_eff | out_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lamps_q <= LAMP_INIT;
      gate_q  <= GATE_INIT;
      fired_q <= 1'b0;
      out_q   <= 1'b0;
      supp_q  <= 1'b0;
    end else begin
      lamps_q <= lamps_d;
      gate_q  <= gate_d;
      fired_q <= fired_d;
      out_q   <= out_d;
      supp_q  <= supp_d;
    end
  end

  assign out        = out_q;
  assign suppressed = supp_q;
  assign lamps      = lamps_q;
  assign gate_state = gate_q;
  assign busy       = (|in) | out_q;

endmodule

// File: tb/tb_lamp_gate_cluster.sv
// Bench for lamp_gate_cluster: directed AND/XOR/faulty scenarios plus random
// traffic on every gate mode, compared against a pass-level behavioural model.
module tb_lamp_gate_cluster;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  int total = 0;
  int bad   = 0;

  // ---------------- helpers for the model ----------------
  function automatic int lc_of(int g);
    case (g)
      0: return 1;
      1: return 3;
      2: return 8;
      3: return 4;
      4: return 5;
      default: return 2;
    endcase
  endfunction

  function automatic logic [7:0] mask_of(int n);
    return 8'((1 << n) - 1);
  endfunction

  function automatic logic [7:0] init_of(int g);
    logic [7:0] base;
    base = 8'h5B;
    return (base >> g) & mask_of(lc_of(g));
  endfunction

  // Gate result from the count of lit lamps.
  function automatic logic model_gate(int mode, logic [7:0] v, int n);
    int ones;
    ones = $countones(v & mask_of(n));
    case (mode)
      0: return ones == n;
      1: return ones > 0;
      2: return ones != n;
      3: return ones == 0;
      4: return (ones % 2) == 1;
      default: return (ones % 2) == 0;
    endcase
  endfunction

  function automatic logic [15:0] lfsr_step(logic [15:0] v);
    if ((v % 2) == 1) return (v >> 1) ^ 16'hB400;
    return v >> 1;
  endfunction

  // ---------------- DUTs ----------------
  logic [1:0] a_in, a_lamps;
  logic       a_lr, a_out, a_sup, a_gs, a_busy;
  lamp_gate_cluster #(.LAMP_COUNT(2), .MODE(0), .FAULTY(0), .LAMP_INIT(2'b00),
                      .LFSR_SEED(16'hACE1)) u_and (
    .clk(clk), .reset(rst_n), .logic_reset(a_lr), .in(a_in), .out(a_out),
    .suppressed(a_sup), .lamps(a_lamps), .gate_state(a_gs), .busy(a_busy));

  logic [1:0] x_in, x_lamps;
  logic       x_lr, x_out, x_sup, x_gs, x_busy;
  lamp_gate_cluster #(.LAMP_COUNT(2), .MODE(4), .FAULTY(0), .LAMP_INIT(2'b00),
                      .LFSR_SEED(16'hACE1)) u_xor (
    .clk(clk), .reset(rst_n), .logic_reset(x_lr), .in(x_in), .out(x_out),
    .suppressed(x_sup), .lamps(x_lamps), .gate_state(x_gs), .busy(x_busy));

  logic [0:0] f1_in, f1_lamps;
  logic       f1_lr, f1_out, f1_sup, f1_gs, f1_busy;
  lamp_gate_cluster #(.LAMP_COUNT(1), .MODE(0), .FAULTY(1), .LAMP_INIT(1'b0),
                      .LFSR_SEED(16'hACE1)) u_f1 (
    .clk(clk), .reset(rst_n), .logic_reset(f1_lr), .in(f1_in), .out(f1_out),
    .suppressed(f1_sup), .lamps(f1_lamps), .gate_state(f1_gs), .busy(f1_busy));

  logic [3:0] f4_in, f4_lamps;
  logic       f4_lr, f4_out, f4_sup, f4_gs, f4_busy;
  lamp_gate_cluster #(.LAMP_COUNT(4), .MODE(0), .FAULTY(1), .LAMP_INIT(4'b0000),
                      .LFSR_SEED(16'hACE1)) u_f4 (
    .clk(clk), .reset(rst_n), .logic_reset(f4_lr), .in(f4_in), .out(f4_out),
    .suppressed(f4_sup), .lamps(f4_lamps), .gate_state(f4_gs), .busy(f4_busy));

  logic [7:0] r_in    [6];
  logic [7:0] r_lamps [6];
  logic [5:0] r_lr, r_out, r_sup, r_gs, r_busy;

  for (genvar g = 0; g < 6; g++) begin : g_rnd
    localparam int LC = lc_of(g);
    lamp_gate_cluster #(.LAMP_COUNT(LC), .MODE(g), .FAULTY(0),
                        .LAMP_INIT(LC'(init_of(g))), .LFSR_SEED(16'hACE1)) u_dut (
      .clk(clk), .reset(rst_n), .logic_reset(r_lr[g]), .in(r_in[g][LC-1:0]),
      .out(r_out[g]), .suppressed(r_sup[g]), .lamps(r_lamps[g][LC-1:0]),
      .gate_state(r_gs[g]), .busy(r_busy[g]));
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    a_in = '0;  a_lr = 1'b0;
    x_in = '0;  x_lr = 1'b0;
    f1_in = '0; f1_lr = 1'b0;
    f4_in = '0; f4_lr = 1'b0;
    r_lr = '0;
    for (int g = 0; g < 6; g++) r_in[g] = '0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [7:0] ini;
    logic       exp_gs;
    idle_all();
    rst_n = 1'b0;
    tick();
    tick();
    total++;
    if ({a_lamps, a_gs, a_out, a_sup, a_busy} !== 6'b000000) begin
      bad++;
      $display("FAIL reset_and: got %b expected 000000", {a_lamps, a_gs, a_out, a_sup, a_busy});
    end
    total++;
    if ({x_lamps, x_gs, x_out, x_sup} !== 5'b00000) begin
      bad++;
      $display("FAIL reset_xor: got %b expected 00000", {x_lamps, x_gs, x_out, x_sup});
    end
    total++;
    if (u_f1.lfsr_val !== 16'hACE1 || u_f4.lfsr_val !== 16'hACE1) begin
      bad++;
      $display("FAIL reset_lfsr: got %h/%h expected ace1", u_f1.lfsr_val, u_f4.lfsr_val);
    end
    for (int g = 0; g < 6; g++) begin
      ini    = init_of(g);
      exp_gs = model_gate(g, ini, lc_of(g));
      total++;
      if ({r_gs[g], r_out[g], r_sup[g], r_lamps[g] & mask_of(lc_of(g))} !== {exp_gs, 2'b00, ini}) begin
        bad++;
        $display("FAIL reset_mode%0d: got gs=%b out=%b sup=%b lamps=%h expected gs=%b lamps=%h",
                 g, r_gs[g], r_out[g], r_sup[g], r_lamps[g] & mask_of(lc_of(g)), exp_gs, ini);
      end
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_and_gate();
    a_in = 2'b01;
    #1;
    total++;
    if (a_busy !== 1'b1) begin
      bad++;
      $display("FAIL and_busy_in: got %b expected 1", a_busy);
    end
    tick();
    total++;
    if ({a_lamps, a_gs, a_out, a_sup} !== 5'b01000) begin
      bad++;
      $display("FAIL and_first: got %b expected 01000", {a_lamps, a_gs, a_out, a_sup});
    end
    a_in = 2'b10;
    tick();
    total++;
    if ({a_lamps, a_gs, a_out, a_sup} !== 5'b11110) begin
      bad++;
      $display("FAIL and_fire: got %b expected 11110", {a_lamps, a_gs, a_out, a_sup});
    end
    a_in = 2'b00;
    #1;
    total++;
    if (a_busy !== 1'b1) begin
      bad++;
      $display("FAIL and_busy_out: got %b expected 1", a_busy);
    end
    tick();
    total++;
    if ({a_lamps, a_gs, a_out, a_sup, a_busy} !== 6'b111000) begin
      bad++;
      $display("FAIL and_pulse_end: got %b expected 111000", {a_lamps, a_gs, a_out, a_sup, a_busy});
    end
  endtask

  task automatic test_fired_flag();
    a_in = 2'b01;
    tick();
    total++;
    if ({a_lamps, a_gs, a_out, a_sup} !== 5'b10001) begin
      bad++;
      $display("FAIL flag_suppress: got %b expected 10001", {a_lamps, a_gs, a_out, a_sup});
    end
    a_in = 2'b00;
    a_lr = 1'b1;
    tick();
    total++;
    if ({a_out, a_sup} !== 2'b00) begin
      bad++;
      $display("FAIL flag_supp_end: got %b expected 00", {a_out, a_sup});
    end
    a_lr = 1'b0;
    a_in = 2'b01;
    tick();
    total++;
    if ({a_lamps, a_gs, a_out, a_sup} !== 5'b11110) begin
      bad++;
      $display("FAIL flag_refire: got %b expected 11110", {a_lamps, a_gs, a_out, a_sup});
    end
    a_in = 2'b00;
    tick();
  endtask

  task automatic test_xor_net_zero();
    x_in = 2'b11;
    tick();
    total++;
    if ({x_lamps, x_gs, x_out, x_sup} !== 5'b11000) begin
      bad++;
      $display("FAIL xor_net_zero: got %b expected 11000", {x_lamps, x_gs, x_out, x_sup});
    end
    x_in = 2'b01;
    tick();
    total++;
    if ({x_lamps, x_gs, x_out, x_sup} !== 5'b10110) begin
      bad++;
      $display("FAIL xor_fire: got %b expected 10110", {x_lamps, x_gs, x_out, x_sup});
    end
    x_in = 2'b00;
    tick();
  endtask

  task automatic test_faulty_single();
    logic [15:0] exp_lfsr;
    exp_lfsr = lfsr_step(lfsr_step(16'hACE1));
    f1_in = 1'b1;
    tick();
    total++;
    if ({f1_lamps, f1_gs, f1_out, f1_sup} !== 4'b1010) begin
      bad++;
      $display("FAIL faulty1_fire: got %b expected 1010", {f1_lamps, f1_gs, f1_out, f1_sup});
    end
    f1_in = 1'b0;
    f1_lr = 1'b1;
    tick();
    f1_lr = 1'b0;
    f1_in = 1'b1;
    tick();
    total++;
    if ({f1_lamps, f1_gs, f1_out, f1_sup} !== 4'b0000) begin
      bad++;
      $display("FAIL faulty1_nofire: got %b expected 0000", {f1_lamps, f1_gs, f1_out, f1_sup});
    end
    f1_in = 1'b0;
    tick();
    tick();
    total++;
    if (u_f1.lfsr_val !== exp_lfsr) begin
      bad++;
      $display("FAIL faulty1_lfsr: got %h expected %h", u_f1.lfsr_val, exp_lfsr);
    end
  endtask

  task automatic test_faulty_rate();
    logic [5:0]  exp_q[$];
    logic [5:0]  exp_v;
    logic [3:0]  m_lamps;
    logic [15:0] m_lfsr;
    int          pop, r, fires, sum_pop, diff;
    m_lamps = 4'b0000;
    m_lfsr  = 16'hACE1;
    fires   = 0;
    sum_pop = 0;
    for (int n = 0; n < 1000; n++) begin
      f4_lr = 1'b1;
      f4_in = 4'($urandom_range(1, 15));
      m_lamps = m_lamps ^ f4_in;
      pop = $countones(m_lamps);
      r   = (int'(m_lfsr) * 4) >>> 16;
      sum_pop += pop;
      exp_q.push_back({(r < pop), 1'b0, m_lamps});
      m_lfsr = lfsr_step(m_lfsr);
      tick();
      exp_v = exp_q.pop_front();
      if (f4_out === 1'b1) fires++;
      total++;
      if ({f4_out, f4_sup, f4_lamps} !== exp_v) begin
        bad++;
        $display("FAIL faulty4_draw%0d: got %b expected %b", n, {f4_out, f4_sup, f4_lamps}, exp_v);
      end
    end
    f4_lr = 1'b0;
    f4_in = '0;
    tick();
    diff = fires * 4 - sum_pop;
    if (diff < 0) diff = -diff;
    total++;
    if (diff > 200) begin
      bad++;
      $display("FAIL faulty4_rate: got fires=%0d expected about %0d (within 50)", fires, sum_pop / 4);
    end
  endtask

  task automatic test_random_modes();
    logic [7:0] m_lamps [6];
    logic       m_gs    [6];
    logic       m_fired [6];
    logic       m_out   [6];
    logic       m_sup   [6];
    logic       ev, chg, fe;
    int         lc;
    for (int g = 0; g < 6; g++) begin
      m_lamps[g] = init_of(g);
      m_gs[g]    = model_gate(g, init_of(g), lc_of(g));
      m_fired[g] = 1'b0;
      m_out[g]   = 1'b0;
      m_sup[g]   = 1'b0;
    end
    for (int n = 0; n < 300; n++) begin
      for (int g = 0; g < 6; g++) begin
        lc = lc_of(g);
        r_in[g] = ($urandom_range(0, 3) == 0) ? 8'h00 : (8'($urandom) & mask_of(lc));
        r_lr[g] = ($urandom_range(0, 3) == 0);
      end
      #1;
      for (int g = 0; g < 6; g++) begin
        total++;
        if (r_busy[g] !== ((|r_in[g]) | m_out[g])) begin
          bad++;
          $display("FAIL rnd_busy_mode%0d: got %b expected %b", g, r_busy[g], (|r_in[g]) | m_out[g]);
        end
        lc  = lc_of(g);
        m_lamps[g] = m_lamps[g] ^ r_in[g];
        ev  = model_gate(g, m_lamps[g], lc);
        chg = (ev != m_gs[g]);
        fe  = m_fired[g] && !r_lr[g];
        m_out[g]   = chg && !fe;
        m_sup[g]   = chg && fe;
        m_fired[g] = fe || m_out[g];
        m_gs[g]    = ev;
      end
      tick();
      for (int g = 0; g < 6; g++) begin
        lc = lc_of(g);
        total++;
        if ({r_out[g], r_sup[g], r_gs[g], r_lamps[g] & mask_of(lc)} !==
            {m_out[g], m_sup[g], m_gs[g], m_lamps[g]}) begin
          bad++;
          $display("FAIL rnd_mode%0d_cyc%0d: got out=%b sup=%b gs=%b lamps=%h expected out=%b sup=%b gs=%b lamps=%h",
                   g, n, r_out[g], r_sup[g], r_gs[g], r_lamps[g] & mask_of(lc),
                   m_out[g], m_sup[g], m_gs[g], m_lamps[g]);
        end
      end
    end
    idle_all();
    tick();
  endtask

  task automatic test_reset_mid();
    a_in = 2'b11;
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({a_lamps, a_gs, a_out, a_sup, a_busy} !== 6'b000001) begin
      bad++;
      $display("FAIL rstmid_async: got %b expected 000001", {a_lamps, a_gs, a_out, a_sup, a_busy});
    end
    tick();
    total++;
    if ({a_lamps, a_gs, a_out, a_sup} !== 5'b00000) begin
      bad++;
      $display("FAIL rstmid_held: got %b expected 00000", {a_lamps, a_gs, a_out, a_sup});
    end
    a_in = 2'b00;
    rst_n = 1'b1;
    tick();
    a_in = 2'b01;
    tick();
    total++;
    if ({a_lamps, a_gs, a_out, a_sup} !== 5'b01000) begin
      bad++;
      $display("FAIL rstmid_resume1: got %b expected 01000", {a_lamps, a_gs, a_out, a_sup});
    end
    a_in = 2'b10;
    tick();
    total++;
    if ({a_lamps, a_gs, a_out, a_sup} !== 5'b11110) begin
      bad++;
      $display("FAIL rstmid_resume2: got %b expected 11110", {a_lamps, a_gs, a_out, a_sup});
    end
    a_in = 2'b00;
    tick();
    total++;
    if ({a_out, a_sup} !== 2'b00) begin
      bad++;
      $display("FAIL rstmid_pulse_end: got %b expected 00", {a_out, a_sup});
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst_n = 1'b0;
    idle_all();
    test_reset();
    test_and_gate();
    test_fired_flag();
    test_xor_net_zero();
    test_faulty_single();
    test_faulty_rate();
    test_random_modes();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
